// File: rtl/rv32i_ifetch.sv
// Purpose: RV32I instruction fetch; reads the ITCM and streams {pc, inst} to decode.
// Latency: 2 cycles issue-to-valid (1-cycle ITCM read + capture into the output buffer).
// Backpressure: out_ready low stops pops; issue stops once buffered + in-flight words reach 2.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   redirect_valid, redirect_pc  load a new fetch PC (bits [1:0] ignored); flushes everything
//   out_valid/out_ready          valid/ready handshake to decode
//   out_inst, out_pc             instruction word and its byte address (buffer head)
//   itcm_wen, itcm_wdata         write side, tied to zero (read-only initiator)
//   itcm_addr, itcm_rdata        byte read address; word returned one cycle later
module rv32i_ifetch #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    WORD_WIDTH = 32,
    parameter int                    MASK_WIDTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_inst,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [MASK_WIDTH-1:0] itcm_wen,
    output logic [ADDR_WIDTH-1:0] itcm_addr,
    output logic [WORD_WIDTH-1:0] itcm_wdata,
    input  logic [WORD_WIDTH-1:0] itcm_rdata
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [WORD_WIDTH-1:0] inst;
    } entry_t;

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic                  inflight;
    logic [ADDR_WIDTH-1:0] inflight_pc;

    entry_t                fifo_q [2];
    logic [1:0]            count;
    logic                  rd_ptr;
    logic                  wr_ptr;

    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [2:0]            occupancy;

    // The two low PC bits never reach the ITCM; redirect targets are word-aligned here.
    logic                  unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign itcm_wen   = '0;
    assign itcm_wdata = '0;
    assign itcm_addr  = fetch_pc;

    assign out_valid = (count != 2'd0) & ~redirect_valid;
    assign pop       = out_valid & out_ready;
    assign out_pc    = fifo_q[rd_ptr].pc;
    assign out_inst  = fifo_q[rd_ptr].inst;

    // A response arriving in a redirect cycle belongs to the abandoned path.
    assign push = inflight & ~redirect_valid;

    // Credit check: words that will occupy the buffer after this cycle's pop.
    // Issuing only while that is below 2 leaves room for the new response.
    assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue     = ~redirect_valid & (occupancy < 3'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            inflight    <= 1'b0;
        end else if (issue) begin
            fetch_pc    <= fetch_pc + ADDR_WIDTH'(4);
            inflight    <= 1'b1;
            inflight_pc <= fetch_pc;
        end else begin
            inflight    <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (redirect_valid) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
        end
    end

    // Payload storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr] <= '{pc: inflight_pc, inst: itcm_rdata};
        end
    end

endmodule

// File: tb/tb_rv32i_ifetch.sv
module tb_rv32i_ifetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [15:0] out_pc;
    logic [3:0]  itcm_wen;
    logic [15:0] itcm_addr;
    logic [31:0] itcm_wdata;
    logic [31:0] itcm_rdata;

    int vectors = 0;
    int miscompares = 0;

    rv32i_ifetch #(
        .ADDR_WIDTH(16), .WORD_WIDTH(32), .MASK_WIDTH(4), .RESET_PC(16'h0000)
    ) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc),
        .itcm_wen(itcm_wen), .itcm_addr(itcm_addr),
        .itcm_wdata(itcm_wdata), .itcm_rdata(itcm_rdata)
    );

    always #5 clk = ~clk;

    // ITCM image: word k holds 0x1000_0000 + k.
    function automatic logic [31:0] word_at(input logic [15:0] a);
        return 32'h1000_0000 + {18'b0, a[15:2]};
    endfunction

    always @(posedge clk) itcm_rdata <= word_at(itcm_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        tick(); tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        vectors++; if (itcm_addr !== 16'h0000) begin miscompares++; $display("FAIL reset_addr got %h exp 0000", itcm_addr); end
        vectors++; if (itcm_wen !== 4'h0) begin miscompares++; $display("FAIL reset_wen got %h exp 0", itcm_wen); end
        vectors++; if (itcm_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_wdata got %h exp 0", itcm_wdata); end
        rst = 1'b0;
        #1;  // cycle 0
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL c0_valid got %b exp 0", out_valid); end
        tick();  // cycle 1
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL c1_valid got %b exp 0", out_valid); end
        vectors++; if (itcm_addr !== 16'h0004) begin miscompares++; $display("FAIL c1_addr got %h exp 0004", itcm_addr); end
        tick();  // cycle 2
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL c2_valid got %b exp 1", out_valid); end
        vectors++; if (out_pc !== 16'h0000) begin miscompares++; $display("FAIL c2_pc got %h exp 0000", out_pc); end
        vectors++; if (out_inst !== 32'h1000_0000) begin miscompares++; $display("FAIL c2_inst got %h exp 10000000", out_inst); end
    endtask

    task automatic test_stream();
        for (int k = 1; k <= 6; k++) begin
            tick();
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid k=%0d got %b exp 1", k, out_valid); end
            vectors++; if (out_pc !== 16'(4 * k)) begin miscompares++; $display("FAIL stream_pc got %h exp %h", out_pc, 16'(4 * k)); end
            vectors++; if (out_inst !== 32'h1000_0000 + k) begin miscompares++; $display("FAIL stream_inst got %h exp %h", out_inst, 32'h1000_0000 + k); end
        end
    endtask

    // Head is 0x1C when the stall begins; fetch_pc is then 0x24 and must freeze there.
    task automatic test_backpressure();
        tick(); out_ready = 1'b0; #1;
        vectors++; if (out_pc !== 16'h001C || out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_start got pc=%h v=%b exp pc=001c v=1", out_pc, out_valid); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            vectors++; if (out_valid !== 1'b1 || out_pc !== 16'h001C) begin miscompares++; $display("FAIL bp_hold_pc got pc=%h v=%b exp pc=001c v=1", out_pc, out_valid); end
            vectors++; if (out_inst !== 32'h1000_0007) begin miscompares++; $display("FAIL bp_hold_inst got %h exp 10000007", out_inst); end
            vectors++; if (itcm_addr !== 16'h0024) begin miscompares++; $display("FAIL bp_addr_frozen got %h exp 0024", itcm_addr); end
        end
        tick(); out_ready = 1'b1; #1;
        vectors++; if (out_valid !== 1'b1 || out_pc !== 16'h001C) begin miscompares++; $display("FAIL bp_release got pc=%h v=%b exp pc=001c v=1", out_pc, out_valid); end
        for (int i = 1; i <= 5; i++) begin
            tick();
            vectors++; if (out_valid !== 1'b1 || out_pc !== 16'(16'h001C + 4 * i)) begin miscompares++; $display("FAIL bp_after_pc got pc=%h v=%b exp pc=%h v=1", out_pc, out_valid, 16'(16'h001C + 4 * i)); end
            vectors++; if (out_inst !== 32'h1000_0007 + i) begin miscompares++; $display("FAIL bp_after_inst got %h exp %h", out_inst, 32'h1000_0007 + i); end
        end
    endtask

    task automatic test_redirect();
        tick(); out_ready = 1'b0;
        tick();
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rd_buffered got %b exp 1", out_valid); end
        redirect_valid = 1'b1; redirect_pc = 16'h0103; #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rd_r0_valid got %b exp 0", out_valid); end
        tick(); redirect_valid = 1'b0; out_ready = 1'b1; #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rd_r1_valid got %b exp 0", out_valid); end
        vectors++; if (itcm_addr !== 16'h0100) begin miscompares++; $display("FAIL rd_r1_addr got %h exp 0100", itcm_addr); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rd_r2_valid got %b exp 0", out_valid); end
        tick();
        vectors++; if (out_valid !== 1'b1 || out_pc !== 16'h0100) begin miscompares++; $display("FAIL rd_r3 got pc=%h v=%b exp pc=0100 v=1", out_pc, out_valid); end
        vectors++; if (out_inst !== 32'h1000_0040) begin miscompares++; $display("FAIL rd_r3_inst got %h exp 10000040", out_inst); end
        tick();
        vectors++; if (out_valid !== 1'b1 || out_pc !== 16'h0104) begin miscompares++; $display("FAIL rd_r4 got pc=%h v=%b exp pc=0104 v=1", out_pc, out_valid); end
    endtask

    task automatic test_simultaneous();
        tick(); redirect_valid = 1'b1; redirect_pc = 16'h0200; out_ready = 1'b1; #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL sim_r0_valid got %b exp 0", out_valid); end
        tick(); redirect_valid = 1'b0; #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL sim_r1_valid got %b exp 0", out_valid); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL sim_r2_valid got %b exp 0", out_valid); end
        tick();
        vectors++; if (out_valid !== 1'b1 || out_pc !== 16'h0200) begin miscompares++; $display("FAIL sim_r3 got pc=%h v=%b exp pc=0200 v=1", out_pc, out_valid); end
        vectors++; if (out_inst !== 32'h1000_0080) begin miscompares++; $display("FAIL sim_r3_inst got %h exp 10000080", out_inst); end
        tick();
        vectors++; if (out_valid !== 1'b1 || out_pc !== 16'h0204) begin miscompares++; $display("FAIL sim_r4 got pc=%h v=%b exp pc=0204 v=1", out_pc, out_valid); end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_pc [4];
        logic [31:0] exp_inst [4];
        exp_pc   = '{16'hFFF8, 16'hFFFC, 16'h0000, 16'h0004};
        exp_inst = '{32'h1000_3FFE, 32'h1000_3FFF, 32'h1000_0000, 32'h1000_0001};
        tick(); redirect_valid = 1'b1; redirect_pc = 16'hFFF8; #1;
        tick(); redirect_valid = 1'b0; #1;
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_r2_valid got %b exp 0", out_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++; if (out_valid !== 1'b1 || out_pc !== exp_pc[i]) begin miscompares++; $display("FAIL wrap_pc got pc=%h v=%b exp pc=%h v=1", out_pc, out_valid, exp_pc[i]); end
            vectors++; if (out_inst !== exp_inst[i]) begin miscompares++; $display("FAIL wrap_inst got %h exp %h", out_inst, exp_inst[i]); end
        end
    endtask

    task automatic test_reset_mid();
        tick(); out_ready = 1'b0;
        tick(); tick();
        #1;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rm_stalled got %b exp 1", out_valid); end
        rst = 1'b1; #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rm_async_valid got %b exp 0", out_valid); end
        vectors++; if (itcm_addr !== 16'h0000) begin miscompares++; $display("FAIL rm_async_addr got %h exp 0000", itcm_addr); end
        vectors++; if (itcm_wen !== 4'h0) begin miscompares++; $display("FAIL rm_wen got %h exp 0", itcm_wen); end
        #1; rst = 1'b0; out_ready = 1'b1; #1;  // cycle 0
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rm_c0_valid got %b exp 0", out_valid); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rm_c1_valid got %b exp 0", out_valid); end
        tick();
        vectors++; if (out_valid !== 1'b1 || out_pc !== 16'h0000) begin miscompares++; $display("FAIL rm_c2 got pc=%h v=%b exp pc=0000 v=1", out_pc, out_valid); end
        vectors++; if (out_inst !== 32'h1000_0000) begin miscompares++; $display("FAIL rm_c2_inst got %h exp 10000000", out_inst); end
        tick();
        vectors++; if (out_valid !== 1'b1 || out_pc !== 16'h0004) begin miscompares++; $display("FAIL rm_c3 got pc=%h v=%b exp pc=0004 v=1", out_pc, out_valid); end
        vectors++; if (itcm_wen !== 4'h0 || itcm_wdata !== 32'h0) begin miscompares++; $display("FAIL rm_wside got wen=%h wdata=%h exp 0", itcm_wen, itcm_wdata); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rv32i_ifetch.md
# rv32i_ifetch

Instruction-fetch initiator for the RV32I core: it drives the read side of the instruction TCM (word-addressed, one-cycle registered read) and delivers a stream of {pc, instruction} pairs to decode over a valid/ready handshake. It holds a sequential PC, accepts redirects from execute (branch/jump), and buffers up to two fetched words so that back-pressure from decode never loses an instruction. It sits between the core pipeline and the ITCM. It never writes the ITCM.

## Interface
- ADDR_WIDTH, 16, byte-address width of the ITCM and width of all PC values
- WORD_WIDTH, 32, instruction and data word width
- MASK_WIDTH, 4, ITCM byte-write-mask width
- RESET_PC, 0, fetch address after reset; must be word aligned
- clk  in  1  sole clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- redirect_valid  in  1  load a new fetch PC this cycle
- redirect_pc  in  ADDR_WIDTH  new fetch byte address; bits [1:0] ignored
- out_valid  out  1  out_inst/out_pc hold a valid instruction
- out_ready  in  1  decode accepts the instruction this cycle
- out_inst  out  WORD_WIDTH  fetched instruction word
- out_pc  out  ADDR_WIDTH  byte address of out_inst
- itcm_wen  out  MASK_WIDTH  constant 0
- itcm_addr  out  ADDR_WIDTH  byte read address; ITCM uses bits [ADDR_WIDTH-1:2]
- itcm_wdata  out  WORD_WIDTH  constant 0
- itcm_rdata  in  WORD_WIDTH  word at the address presented in the previous cycle

## Operation
- **State**
  - fetch_pc (ADDR_WIDTH): next address to request.
  - inflight flag plus inflight_pc: a request was issued last cycle.
  - Two-entry FIFO of {pc, inst} with a 2-bit count.
- **Address output**
  - itcm_addr = fetch_pc combinationally, every cycle.
  - Reads are side-effect free, so non-issue cycles are harmless.
- **Pop**
  - pop = out_valid & out_ready.
  - out_valid = (count != 0) & ~redirect_valid.
  - out_inst/out_pc come from the FIFO head.
- **Issue**
  - issue = ~redirect_valid & (count + inflight − pop < 2).
  - On issue: fetch_pc <= fetch_pc + 4, inflight <= 1, inflight_pc <= fetch_pc.
  - Otherwise inflight <= 0 and fetch_pc holds.
- **Capture**
  - If inflight & ~redirect_valid, push {inflight_pc, itcm_rdata} into the FIFO.
  - The credit rule guarantees the FIFO never overflows.
  - A simultaneous push and pop is legal; count is unchanged.
- **Redirect**
  - Redirect has priority over everything.
  - The FIFO is flushed (count <= 0), the inflight response arriving this cycle is discarded, and inflight <= 0.
  - fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
  - No issue and no pop occur in the redirect cycle.
- **Arithmetic:** PC increment is modulo 2^ADDR_WIDTH; 0xFFFC + 4 wraps to 0x0000 (ADDR_WIDTH=16).
- **Reset**
  - Clears count, inflight and inflight_pc, and sets fetch_pc = RESET_PC, asynchronously at any point, including mid-stream.
  - Discards all buffered and in-flight words.

## Timing
- **Reset values:** out_valid=0, itcm_addr=RESET_PC, itcm_wen=0, itcm_wdata=0. out_inst and out_pc are don't-care while out_valid=0.
- **Issue-to-valid latency:** 2 cycles. Issue in cycle N, itcm_rdata valid in N+1, written at the end of N+1, out_valid in N+2.
- **After reset deassertion:** first issue in the first clock after deassertion (cycle 0); out_valid=1 in cycle 2 with out_pc=RESET_PC.
- **Redirect:** redirect in cycle R; first issue in R+1; out_valid with the redirect target in R+3.
- **Throughput:** one instruction per cycle while out_ready=1.
- **Stall:** with out_ready=0, at most 2 words are buffered, then issue stops. out_inst/out_pc stay stable while out_valid=1 and out_ready=0.
- **Stall release:** first pop in the same cycle out_ready rises; issue resumes in that cycle.
- **Protocol rule:** out_valid never drops without a pop, except on redirect or reset.

## Test plan
- **Reset and stream:** ITCM word k = 0x1000_0000+k, RESET_PC=0, out_ready=1. Expect out_valid rising in cycle 2, then out_pc 0x0,0x4,0x8,… with out_inst 0x1000_0000,0x1000_0001,… every cycle.
- **Back-pressure:** drop out_ready for 5 cycles mid-stream. Expect out_inst held stable, at most 2 buffered, no address skipped or duplicated after release, and itcm_addr frozen once full.
- **Redirect:** assert redirect_valid with redirect_pc=0x0103 while 2 words are buffered. Expect out_valid=0 in that cycle and the next two, then out_pc=0x0100 in R+3, and neither buffered word ever delivered.
- **Simultaneous events:** redirect in a cycle with out_ready=1 and a response arriving. Expect no pop, the response discarded, and the next delivered pc equal to the redirect target.
- **Wrap:** redirect to 0xFFF8. Expect out_pc 0xFFF8, 0xFFFC, 0x0000, 0x0004.
- **Reset mid-operation:** pulse rst asynchronously (between edges) during a stall with 2 buffered. Expect out_valid=0 immediately, then restart from RESET_PC with the 2-cycle latency; itcm_wen stays 0 throughout.
